// File: rtl/codix_risc_ca_core_main_id_issue_ctrl.sv
// ID-stage issue controller: 2-entry fetch queue feeding the decoder, with
// multi-cycle/branch sequencing. Optional issue counter: CODIX_ID_ISSUE_PERF_CNT_EN.
module codix_risc_ca_core_main_id_issue_ctrl #(
  parameter int unsigned INSTR_W = 12,
  parameter logic [3:0]  MUL_OPC = 4'hF,
  parameter logic [3:0]  BR_OPC  = 4'hE,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               if_ready,
  input  logic               flush,
  input  logic               ex_stall,
  output logic               ACT,
  output logic [INSTR_W-1:0] id_instr_Q0,
  output logic               busy
`ifdef CODIX_ID_ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]        issued_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, MULTI, BUBBLE} state_t;

  localparam logic [2:0] MULTI_INIT = 3'(MUL_LAT - 2);

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt;
  logic               issue;
  logic [INSTR_W-1:0] q_mem [2];
  logic               q_rd, q_wr;
  logic [1:0]         q_cnt;
  logic               q_empty, push, pop;
  logic [3:0]         opc;

  assign q_empty  = (q_cnt == 2'd0);
  assign if_ready = (q_cnt < 2'd2);
  assign ACT      = (state == ISSUE);
  assign busy     = !q_empty || (state != IDLE);
  assign opc      = id_instr_Q0[INSTR_W-1 -: 4];
  assign push     = if_valid && if_ready && !flush;
  assign pop      = issue && !flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    if (!ex_stall) begin
      case (state)
        IDLE, BUBBLE: begin
          if (!q_empty) issue = 1'b1;
          else          state_nxt = IDLE;
        end
        ISSUE: begin
          if (opc == MUL_OPC) begin
            state_nxt = MULTI;
            cnt_nxt   = MULTI_INIT;
          end else if (opc == BR_OPC) begin
            state_nxt = BUBBLE;
          end else if (!q_empty) begin
            issue = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        MULTI: begin
          if (cnt != 3'd0)   cnt_nxt = cnt - 3'd1;
          else if (!q_empty) issue = 1'b1;
          else               state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (issue) state_nxt = ISSUE;
  end

  // Flush overrides the next-state logic but leaves id_instr_Q0 untouched.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      cnt         <= '0;
      id_instr_Q0 <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (issue) id_instr_Q0 <= q_mem[q_rd];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q_mem <= '{default: '0};
      q_rd  <= 1'b0;
      q_wr  <= 1'b0;
      q_cnt <= '0;
    end else if (flush) begin
      q_rd  <= 1'b0;
      q_wr  <= 1'b0;
      q_cnt <= '0;
    end else begin
      if (push) begin
        q_mem[q_wr] <= if_instr;
        q_wr        <= ~q_wr;
      end
      if (pop) q_rd <= ~q_rd;
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef CODIX_ID_ISSUE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                           issued_cnt <= '0;
    else if (pop && issued_cnt != '1)   issued_cnt <= issued_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_codix_risc_ca_core_main_id_issue_ctrl.sv
// Self-checking bench: directed test-plan sequences plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_codix_risc_ca_core_main_id_issue_ctrl;
  localparam int unsigned W   = 12;
  localparam int unsigned LAT = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         if_valid = 1'b0;
  logic [W-1:0] if_instr = '0;
  logic         flush = 1'b0;
  logic         ex_stall = 1'b0;
  logic         if_ready, ACT, busy;
  logic [W-1:0] id_instr_Q0;
`ifdef CODIX_ID_ISSUE_PERF_CNT_EN
  logic [15:0]  issued_cnt;
`endif

  codix_risc_ca_core_main_id_issue_ctrl #(
    .INSTR_W(W), .MUL_OPC(4'hF), .BR_OPC(4'hE), .MUL_LAT(LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .ex_stall(ex_stall), .ACT(ACT),
    .id_instr_Q0(id_instr_Q0), .busy(busy)
`ifdef CODIX_ID_ISSUE_PERF_CNT_EN
    , .issued_cnt(issued_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: FIFO contents, current issued word, idle cycles owed.
  logic [W-1:0] m_q[$];
  logic         m_act;
  logic [W-1:0] m_instr;
  int           m_shadow;
  int           m_cnt;

  function automatic int penalty(input logic [W-1:0] w);
    if (w[W-1 -: 4] == 4'hF) return LAT - 1;
    if (w[W-1 -: 4] == 4'hE) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_act = 1'b0; m_instr = '0; m_shadow = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic st, input logic fl);
    int  pre;
    bit  try_issue;
    pre = m_q.size();
    if (fl) begin
      m_q.delete(); m_act = 1'b0; m_shadow = 0;
    end else begin
      if (!st) begin
        try_issue = 0;
        if (m_act) begin
          if (penalty(m_instr) == 0) try_issue = 1;
          else begin m_act = 1'b0; m_shadow = penalty(m_instr); end
        end else if (m_shadow > 1) m_shadow--;
        else begin m_shadow = 0; try_issue = 1; end
        if (try_issue) begin
          if (m_q.size() > 0) begin
            m_instr = m_q.pop_front(); m_act = 1'b1;
            if (m_cnt < 16'hFFFF) m_cnt++;
          end else m_act = 1'b0;
        end
      end
      if (v && pre < 2) m_q.push_back(d);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ACT", 32'(ACT), 32'(m_act));
    chk("id_instr_Q0", 32'(id_instr_Q0), 32'(m_instr));
    chk("busy", 32'(busy), 32'(m_shadow != 0 || m_act || m_q.size() != 0));
    chk("if_ready", 32'(if_ready), 32'(m_q.size() < 2));
`ifdef CODIX_ID_ISSUE_PERF_CNT_EN
    chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic st, input logic fl);
    if_valid = v; if_instr = d; ex_stall = st; flush = fl;
    @(posedge CLK);
    model_step(v, d, st, fl);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic lit(input string name, input logic a, input logic [W-1:0] w);
    chk({name, "_act"}, 32'(ACT), 32'(a));
    if (a) chk({name, "_instr"}, 32'(id_instr_Q0), 32'(w));
  endtask

  task automatic do_reset();
    RST = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    chk("rst_act", 32'(ACT), 32'd0);
    chk("rst_instr", 32'(id_instr_Q0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(if_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] opc;
    do_reset();

    // Plain back-to-back issue
    step(1, 12'h123, 0, 0); lit("p0", 0, '0);
    step(1, 12'h456, 0, 0); lit("p1", 1, 12'h123);
    step(1, 12'h789, 0, 0); lit("p2", 1, 12'h456);
    step(0, '0, 0, 0);      lit("p3", 1, 12'h789);
    step(0, '0, 0, 0);      lit("p4", 0, '0); chk("p4_busy", 32'(busy), 32'd0);

    // Multi-cycle: 1 ACT + 3 idle
    step(1, 12'hF01, 0, 0);
    step(1, 12'h002, 0, 0); lit("m1", 1, 12'hF01);
    for (int i = 0; i < 3; i++) begin step(0, '0, 0, 0); lit("m_idle", 0, '0); end
    step(0, '0, 0, 0);      lit("m5", 1, 12'h002);
    step(0, '0, 0, 0);

    // Branch: exactly one bubble
    step(1, 12'hE10, 0, 0);
    step(1, 12'h011, 0, 0); lit("b1", 1, 12'hE10);
    step(0, '0, 0, 0);      lit("b2", 0, '0);
    step(0, '0, 0, 0);      lit("b3", 1, 12'h011);
    step(0, '0, 0, 0);

    // Stall holds ACT/instr while the queue fills
    step(1, 12'h0AA, 0, 0);
    step(0, '0, 0, 0);      lit("s0", 1, 12'h0AA);
    step(1, 12'h0B1, 1, 0); lit("s1", 1, 12'h0AA);
    step(1, 12'h0B2, 1, 0); lit("s2", 1, 12'h0AA);
    step(0, '0, 1, 0);      lit("s3", 1, 12'h0AA); chk("s3_ready", 32'(if_ready), 32'd0);
    step(0, '0, 0, 0);      lit("s4", 1, 12'h0B1);
    step(0, '0, 0, 0);      lit("s5", 1, 12'h0B2);
    step(0, '0, 0, 0);

    // Flush mid-MULTI with two queued words and a same-cycle push
    step(1, 12'hF03, 0, 0);
    step(1, 12'h0C1, 0, 0); lit("f1", 1, 12'hF03);
    step(1, 12'h0C2, 0, 0); lit("f2", 0, '0);
    step(1, 12'h0C3, 0, 1);
    lit("f3", 0, '0);
    chk("f3_busy", 32'(busy), 32'd0);
    chk("f3_ready", 32'(if_ready), 32'd1);
    chk("f3_hold", 32'(id_instr_Q0), 32'h0F03);
    for (int i = 0; i < 4; i++) begin step(0, '0, 0, 0); lit("f_after", 0, '0); end

    // Issue count with a 2-cycle stall, then asynchronous reset mid-stream
    do_reset();
    step(1, 12'h001, 0, 0);
    step(1, 12'h002, 0, 0); lit("c1", 1, 12'h001);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);      lit("c3", 1, 12'h001);
    step(1, 12'h003, 0, 0);
    step(1, 12'h004, 0, 0);
    step(1, 12'h005, 0, 0);
    step(0, '0, 0, 0);      lit("c7", 1, 12'h005);
    step(0, '0, 0, 0);
`ifdef CODIX_ID_ISSUE_PERF_CNT_EN
    chk("issued_cnt_5", 32'(issued_cnt), 32'd5);
`endif
    step(1, 12'h006, 0, 0);
    step(1, 12'h007, 0, 0);
    step(1, 12'h008, 0, 0); lit("r0", 1, 12'h007);
    #2 RST = 1'b0;
    #1;
    chk("arst_act", 32'(ACT), 32'd0);
    chk("arst_instr", 32'(id_instr_Q0), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(if_ready), 32'd1);
`ifdef CODIX_ID_ISSUE_PERF_CNT_EN
    chk("arst_cnt", 32'(issued_cnt), 32'd0);
`endif
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(7))
        0:       opc = 4'hF;
        1:       opc = 4'hE;
        default: opc = 4'($urandom_range(13));
      endcase
      step(($urandom_range(3) != 0), {opc, 8'($urandom)},
           ($urandom_range(4) == 0), ($urandom_range(39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
